// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//   Hazard unit for the 5-stage pipeline. It produces every stall and flush
//   control, the E-stage operand forwarding selects, handles a fixed-latency
//   long (mul/div) operation in E and a variable-latency memory in M, and
//   keeps a saturating count of front-end stall cycles.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   Rs1D, Rs2D                 D-stage source registers
//   Rs1E, Rs2E, RdE            E-stage sources / destination
//   RdM, RdW                   M / W destinations
//   RegWriteE/M/W              register write enables per stage
//   ResultSrcE0                load resident in E
//   PCSrcE                     taken branch/jump in E
//   LongStartE                 long op resident in E
//   MemReqM, MemReadyM         memory request in M / completes this cycle
//   ForwardAE, ForwardBE       00 regfile, 01 W result, 10 M ALU result
//   StallF/D/E/M               hold stage register
//   FlushD/E/M/W               clear stage register (insert bubble)
//   LongBusy                   long-op FSM is not in RUN
//   StallCount                 saturating count of cycles with StallF=1
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int REG_AW   = 5,
    parameter int LONG_LAT = 4,
    parameter int CNT_W    = 32,
    parameter int FWD_EN   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteE,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              ResultSrcE0,
    input  logic              PCSrcE,
    input  logic              LongStartE,
    input  logic              MemReqM,
    input  logic              MemReadyM,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic              FlushW,
    output logic              LongBusy,
    output logic [CNT_W-1:0]  StallCount
);

    // Counter is at least one bit wide so LONG_LAT=1 still elaborates.
    localparam int CW = (LONG_LAT > 1) ? $clog2(LONG_LAT) : 1;
    localparam logic [CW-1:0]     CNT_ZERO = CW'(0);
    localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]     CNT_LOAD = CW'((LONG_LAT > 1) ? (LONG_LAT - 2) : 0);
    localparam logic              LONG_EN  = (LONG_LAT > 1);
    localparam logic [REG_AW-1:0] REG_X0   = {REG_AW{1'b0}};
    localparam logic [CNT_W-1:0]  SC_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  SC_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  SC_ZERO  = CNT_W'(0);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_r;
    logic [CW-1:0]     cnt_r;
    logic [CNT_W-1:0]  stallCount_r;

    logic memStall_s;
    logic rawStall_s;
    logic longStall_s;

    // Operand forwarding selects for the E stage.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (FWD_EN != 0) begin
            if ((Rs1E == RdM) && RegWriteM && (Rs1E != REG_X0)) begin
                ForwardAE = 2'b10;
            end else if ((Rs1E == RdW) && RegWriteW && (Rs1E != REG_X0)) begin
                ForwardAE = 2'b01;
            end else begin
                ForwardAE = 2'b00;
            end
            if ((Rs2E == RdM) && RegWriteM && (Rs2E != REG_X0)) begin
                ForwardBE = 2'b10;
            end else if ((Rs2E == RdW) && RegWriteW && (Rs2E != REG_X0)) begin
                ForwardBE = 2'b01;
            end else begin
                ForwardBE = 2'b00;
            end
        end else begin
            ForwardAE = 2'b00;
            ForwardBE = 2'b00;
        end
    end

    // Read-after-write detection for the instruction in D.
    always_comb begin
        rawStall_s = 1'b0;
        if (FWD_EN != 0) begin
            // Only a load result is too late to forward.
            rawStall_s = ResultSrcE0 && RegWriteE && (RdE != REG_X0) &&
                         ((Rs1D == RdE) || (Rs2D == RdE));
        end else begin
            // Without forwarding, wait until the producer reaches W; the
            // regfile writes in the first half-cycle so W itself is safe.
            rawStall_s = ((Rs1D != REG_X0) &&
                          (((Rs1D == RdE) && RegWriteE) || ((Rs1D == RdM) && RegWriteM))) ||
                         ((Rs2D != REG_X0) &&
                          (((Rs2D == RdE) && RegWriteE) || ((Rs2D == RdM) && RegWriteM)));
        end
    end

    // Long-op stall request; forced low while reset is asserted.
    always_comb begin
        longStall_s = 1'b0;
        case (state_r)
            RUN:     longStall_s = LongStartE && LONG_EN;
            BUSY:    longStall_s = (cnt_r != CNT_ZERO);
            DONE:    longStall_s = 1'b0;
            default: longStall_s = 1'b0;
        endcase
        if (reset) begin
            longStall_s = 1'b0;
        end else begin
            longStall_s = longStall_s;
        end
    end

    // Stage stall/flush equations; memory stall wins over any flush.
    always_comb begin
        memStall_s = MemReqM && !MemReadyM;
        StallE     = memStall_s || longStall_s;
        StallF     = StallE || rawStall_s;
        StallD     = StallE || rawStall_s;
        StallM     = memStall_s;
        FlushW     = memStall_s;
        FlushM     = longStall_s && !memStall_s;
        FlushE     = !StallE && (rawStall_s || PCSrcE);
        FlushD     = !StallE && PCSrcE;
    end

    // Long-op FSM: RUN -> BUSY counts down, DONE holds off retrigger while
    // E is still frozen by the memory.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= RUN;
            cnt_r   <= CNT_ZERO;
        end else begin
            case (state_r)
                RUN: begin
                    if (LongStartE && LONG_EN) begin
                        cnt_r   <= CNT_LOAD;
                        state_r <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_r != CNT_ZERO) begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end else if (!StallE) begin
                        state_r <= RUN;
                    end else begin
                        state_r <= DONE;
                    end
                end
                DONE: begin
                    if (!StallE) begin
                        state_r <= RUN;
                    end
                end
                default: begin
                    state_r <= RUN;
                    cnt_r   <= CNT_ZERO;
                end
            endcase
        end
    end

    // Saturating front-end stall-cycle counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stallCount_r <= SC_ZERO;
        end else if (StallF && (stallCount_r != SC_MAX)) begin
            stallCount_r <= stallCount_r + SC_ONE;
        end
    end

    assign LongBusy   = (state_r != RUN);
    assign StallCount = stallCount_r;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: instance a is forwarding, LONG_LAT=4, CNT_W=3;
// instance b is interlock-only, LONG_LAT=1. Both share the same inputs.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteE, RegWriteM, RegWriteW, ResultSrcE0, PCSrcE;
    logic       LongStartE, MemReqM, MemReadyM;

    logic [1:0]  aFwdA, aFwdB, bFwdA, bFwdB;
    logic        aStallF, aStallD, aStallE, aStallM, aFlushD, aFlushE, aFlushM, aFlushW, aBusy;
    logic        bStallF, bStallD, bStallE, bStallM, bFlushD, bFlushE, bFlushM, bFlushW, bBusy;
    logic [2:0]  aCount;
    logic [31:0] bCount;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.REG_AW(5), .LONG_LAT(4), .CNT_W(3), .FWD_EN(1)) dutA (
        .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
        .RegWriteW(RegWriteW), .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
        .LongStartE(LongStartE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .ForwardAE(aFwdA), .ForwardBE(aFwdB), .StallF(aStallF), .StallD(aStallD),
        .StallE(aStallE), .StallM(aStallM), .FlushD(aFlushD), .FlushE(aFlushE),
        .FlushM(aFlushM), .FlushW(aFlushW), .LongBusy(aBusy), .StallCount(aCount));

    hazard_scoreboard #(.REG_AW(5), .LONG_LAT(1), .CNT_W(32), .FWD_EN(0)) dutB (
        .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
        .RegWriteW(RegWriteW), .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
        .LongStartE(LongStartE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .ForwardAE(bFwdA), .ForwardBE(bFwdB), .StallF(bStallF), .StallD(bStallD),
        .StallE(bStallE), .StallM(bStallM), .FlushD(bFlushD), .FlushE(bFlushE),
        .FlushM(bFlushM), .FlushW(bFlushW), .LongBusy(bBusy), .StallCount(bCount));

    task automatic idle();
        Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
        RdE = 5'd0; RdM = 5'd0; RdW = 5'd0;
        RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
        ResultSrcE0 = 1'b0; PCSrcE = 1'b0; LongStartE = 1'b0;
        MemReqM = 1'b0; MemReadyM = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        @(negedge clk);
        LongStartE = 1'b1;
        #1;
        checks++; if (aCount !== 3'd0) begin errors++; $display("FAIL rst_countA got=%0d exp=0", aCount); end
        checks++; if (bCount !== 32'd0) begin errors++; $display("FAIL rst_countB got=%0d exp=0", bCount); end
        checks++; if (aBusy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", aBusy); end
        checks++; if (aStallE !== 1'b0) begin errors++; $display("FAIL rst_stallE got=%b exp=0", aStallE); end
        checks++; if (aFlushM !== 1'b0) begin errors++; $display("FAIL rst_flushM got=%b exp=0", aFlushM); end
        @(negedge clk);
        idle();
        reset = 1'b0;
    endtask

    task automatic test_forward();
        @(negedge clk);
        idle();
        RdM = 5'd5; RdW = 5'd5; RegWriteM = 1'b1; RegWriteW = 1'b1; Rs1E = 5'd5;
        #1;
        checks++; if (aFwdA !== 2'b10) begin errors++; $display("FAIL fwd_mprio got=%b exp=10", aFwdA); end
        checks++; if (bFwdA !== 2'b00) begin errors++; $display("FAIL fwd_disabled got=%b exp=00", bFwdA); end
        @(negedge clk);
        RegWriteM = 1'b0; Rs1E = 5'd3; Rs2E = 5'd5;
        #1;
        checks++; if (aFwdB !== 2'b01) begin errors++; $display("FAIL fwd_w got=%b exp=01", aFwdB); end
        checks++; if (aFwdA !== 2'b00) begin errors++; $display("FAIL fwd_none got=%b exp=00", aFwdA); end
        @(negedge clk);
        RegWriteM = 1'b1; RdM = 5'd0; RdW = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
        #1;
        checks++; if (aFwdA !== 2'b00) begin errors++; $display("FAIL fwd_x0 got=%b exp=00", aFwdA); end
        checks++; if (aStallF !== 1'b0) begin errors++; $display("FAIL fwd_nostall got=%b exp=0", aStallF); end
    endtask

    task automatic test_raw();
        @(negedge clk);
        idle();
        ResultSrcE0 = 1'b1; RegWriteE = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
        #1;
        checks++; if ({aStallF, aStallD, aFlushE} !== 3'b111) begin errors++; $display("FAIL raw_load got=%b exp=111", {aStallF, aStallD, aFlushE}); end
        checks++; if ({aStallE, aFlushD} !== 2'b00) begin errors++; $display("FAIL raw_load_e got=%b exp=00", {aStallE, aFlushD}); end
        @(negedge clk);
        RdE = 5'd0; Rs2D = 5'd0;
        #1;
        checks++; if ({aStallF, aFlushE} !== 2'b00) begin errors++; $display("FAIL raw_x0 got=%b exp=00", {aStallF, aFlushE}); end
        @(negedge clk);
        idle();
        RegWriteE = 1'b1; RdE = 5'd7; Rs1D = 5'd7;
        #1;
        checks++; if (aStallF !== 1'b0) begin errors++; $display("FAIL raw_alu_fwd got=%b exp=0", aStallF); end
        checks++; if ({bStallF, bFlushE} !== 2'b11) begin errors++; $display("FAIL raw_interlock_e got=%b exp=11", {bStallF, bFlushE}); end
        @(negedge clk);
        idle();
        RegWriteM = 1'b1; RdM = 5'd9; Rs2D = 5'd9;
        #1;
        checks++; if (bStallD !== 1'b1) begin errors++; $display("FAIL raw_interlock_m got=%b exp=1", bStallD); end
        @(negedge clk);
        idle();
        RegWriteE = 1'b1; RdE = 5'd0; Rs1D = 5'd0;
        #1;
        checks++; if (bStallF !== 1'b0) begin errors++; $display("FAIL raw_interlock_x0 got=%b exp=0", bStallF); end
        checks++; if (aCount !== 3'd1) begin errors++; $display("FAIL raw_count got=%0d exp=1", aCount); end
    endtask

    task automatic test_long();
        logic [3:0] expStall;
        logic [3:0] expBusy;
        expStall = 4'b0111;
        expBusy  = 4'b1110;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            idle();
            LongStartE = 1'b1;
            #1;
            checks++; if ({aStallE, aFlushM, aStallF} !== {3{expStall[i]}}) begin errors++; $display("FAIL long_c%0d stallE/flushM/stallF got=%b exp=%b", i + 1, {aStallE, aFlushM, aStallF}, {3{expStall[i]}}); end
            checks++; if (aBusy !== expBusy[i]) begin errors++; $display("FAIL long_c%0d busy got=%b exp=%b", i + 1, aBusy, expBusy[i]); end
            checks++; if (bStallE !== 1'b0) begin errors++; $display("FAIL long_lat1_c%0d got=%b exp=0", i + 1, bStallE); end
        end
        @(negedge clk);
        idle();
        #1;
        checks++; if ({aBusy, aStallE} !== 2'b00) begin errors++; $display("FAIL long_end got=%b exp=00", {aBusy, aStallE}); end
        checks++; if (aCount !== 3'd4) begin errors++; $display("FAIL long_count got=%0d exp=4", aCount); end
        // Reset in the middle of a long op.
        @(negedge clk);
        LongStartE = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if ({aBusy, aStallE, aFlushM} !== 3'b000) begin errors++; $display("FAIL long_reset got=%b exp=000", {aBusy, aStallE, aFlushM}); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (aStallE !== 1'b1) begin errors++; $display("FAIL long_restart got=%b exp=1", aStallE); end
        @(negedge clk);
        idle();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_long_mem();
        logic [5:0] memS;
        logic [5:0] expStallE;
        logic [5:0] expFlushM;
        logic [5:0] expBusy;
        memS      = 6'b011000;
        expStallE = 6'b011111;
        expFlushM = 6'b000111;
        expBusy   = 6'b111110;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            idle();
            LongStartE = 1'b1;
            MemReqM = memS[i];
            MemReadyM = (i == 5) ? 1'b1 : 1'b0;
            if (i == 5) MemReqM = 1'b1;
            #1;
            checks++; if (aStallE !== expStallE[i]) begin errors++; $display("FAIL lmem_c%0d stallE got=%b exp=%b", i + 1, aStallE, expStallE[i]); end
            checks++; if (aFlushM !== expFlushM[i]) begin errors++; $display("FAIL lmem_c%0d flushM got=%b exp=%b", i + 1, aFlushM, expFlushM[i]); end
            checks++; if (aFlushW !== memS[i]) begin errors++; $display("FAIL lmem_c%0d flushW got=%b exp=%b", i + 1, aFlushW, memS[i]); end
            checks++; if (aBusy !== expBusy[i]) begin errors++; $display("FAIL lmem_c%0d busy got=%b exp=%b", i + 1, aBusy, expBusy[i]); end
        end
        @(negedge clk);
        idle();
        #1;
        checks++; if ({aBusy, aStallE} !== 2'b00) begin errors++; $display("FAIL lmem_end got=%b exp=00", {aBusy, aStallE}); end
    endtask

    task automatic test_branch_mem();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            idle();
            PCSrcE = 1'b1; MemReqM = 1'b1; MemReadyM = (i == 2) ? 1'b1 : 1'b0;
            #1;
            if (i < 2) begin
                checks++; if ({aFlushD, aFlushE, aStallE, aStallM} !== 4'b0011) begin errors++; $display("FAIL br_mem_c%0d got=%b exp=0011", i + 1, {aFlushD, aFlushE, aStallE, aStallM}); end
            end else begin
                checks++; if ({aFlushD, aFlushE, aStallE, aStallM} !== 4'b1100) begin errors++; $display("FAIL br_mem_ready got=%b exp=1100", {aFlushD, aFlushE, aStallE, aStallM}); end
            end
        end
        @(negedge clk);
        idle();
        PCSrcE = 1'b1; ResultSrcE0 = 1'b1; RegWriteE = 1'b1; RdE = 5'd7; Rs1D = 5'd7;
        #1;
        checks++; if ({aFlushD, aFlushE, aStallF, aStallD} !== 4'b1111) begin errors++; $display("FAIL br_raw got=%b exp=1111", {aFlushD, aFlushE, aStallF, aStallD}); end
    endtask

    task automatic test_stall_count();
        @(negedge clk);
        idle();
        reset = 1'b1;
        #1;
        checks++; if (aCount !== 3'd0) begin errors++; $display("FAIL cnt_clear got=%0d exp=0", aCount); end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            ResultSrcE0 = (i < 10); RegWriteE = 1'b1; RdE = 5'd4; Rs1D = 5'd4;
            #1;
            if (i == 3) begin
                checks++; if (aCount !== 3'd3) begin errors++; $display("FAIL cnt_mid got=%0d exp=3", aCount); end
            end
            if (i == 10) begin
                checks++; if (aCount !== 3'd7) begin errors++; $display("FAIL cnt_sat got=%0d exp=7", aCount); end
            end
        end
        @(negedge clk);
        idle();
        reset = 1'b1;
        #1;
        checks++; if (aCount !== 3'd0) begin errors++; $display("FAIL cnt_reset got=%0d exp=0", aCount); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_forward();
        test_raw();
        test_long();
        test_long_mem();
        test_branch_mem();
        test_stall_count();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard unit for the 5-stage pipeline. It adds three things to the existing forward/stall/flush duties: a multi-cycle execute unit (mul/div) that holds E for a fixed latency, a variable-latency data-memory handshake in M, and a no-forwarding mode. It is the sole source of all stall and flush controls, and it carries a saturating front-end stall-cycle counter for performance analysis.

## Interface
- REG_AW, 5, register address width
- LONG_LAT, 4, cycles a long op occupies E (>=1; 1 means no long-op stall)
- CNT_W, 32, stall counter width
- FWD_EN, 1, 1 = forwarding, 0 = interlock-only

- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- Rs1D, Rs2D  in  REG_AW  D-stage sources
- Rs1E, Rs2E, RdE  in  REG_AW  E-stage sources/destination
- RdM, RdW  in  REG_AW  M/W destinations
- RegWriteE, RegWriteM, RegWriteW  in  1  write enables per stage
- ResultSrcE0  in  1  load in E
- PCSrcE  in  1  taken branch/jump in E
- LongStartE  in  1  long op resident in E
- MemReqM  in  1  load/store in M
- MemReadyM  in  1  memory completes this cycle
- ForwardAE, ForwardBE  out  2  00 regfile, 01 W result, 10 M ALU result
- StallF, StallD, StallE, StallM  out  1  hold stage register
- FlushD, FlushE, FlushM, FlushW  out  1  clear stage register (bubble)
- LongBusy  out  1  FSM not in RUN
- StallCount  out  CNT_W  cycles with StallF=1, saturating

## Operation
- Forwarding (FWD_EN=1):
  - ForwardAE=10 if Rs1E==RdM & RegWriteM & Rs1E!=0.
  - Else 01 if Rs1E==RdW & RegWriteW & Rs1E!=0.
  - Else 00. ForwardBE uses the same rules on Rs2E.
  - The x0 comparison is full REG_AW wide.
- FWD_EN=0: ForwardAE/BE are always 00.
- memStall = MemReqM & ~MemReadyM.
- rawStall:
  - FWD_EN=1: ResultSrcE0 & RegWriteE & RdE!=0 & (Rs1D==RdE | Rs2D==RdE).
  - FWD_EN=0: for each nonzero Rs1D/Rs2D, a match with (RdE & RegWriteE) or (RdM & RegWriteM). W needs no check because the regfile writes on the first half-cycle.
- Long-op FSM (2-bit state plus counter of clog2(LONG_LAT) bits):
  - RUN: longStall = LongStartE & (LONG_LAT>1). On that condition, cnt<=LONG_LAT-2 and go to BUSY.
  - BUSY: longStall = (cnt!=0). If cnt!=0, cnt<=cnt-1. If cnt==0, go to RUN when ~StallE, else go to DONE.
  - DONE: longStall=0. Go to RUN when ~StallE. This state blocks retriggering while E is held by memStall.
  - The counter decrements regardless of memStall.
- Output equations:
  - StallE = memStall | longStall
  - StallF = StallD = StallE | rawStall
  - StallM = FlushW = memStall
  - FlushM = longStall & ~memStall
  - FlushE = ~StallE & (rawStall | PCSrcE)
  - FlushD = ~StallE & PCSrcE. A branch held in E redirects only when it advances.
- StallCount increments by 1 each cycle StallF=1 and holds at all-ones.

## Timing
- Reset values: state=RUN, cnt=0, StallCount=0, LongBusy=0.
- With reset asserted, all other outputs follow the combinational equations with longStall=0.
- All outputs except StallCount and LongBusy are combinational from inputs and state, in the same cycle.
- Long op with memory idle: the op sits in E for exactly LONG_LAT cycles, with StallE high for the first LONG_LAT-1 of them. Each stalled cycle inserts one M bubble.
- Reset asserted mid long-op: immediate return to RUN and longStall drops asynchronously. The counter restarts only on the next LongStartE seen in RUN.
- Simultaneous events:
  - memStall overrides every flush of a stalled stage.
  - PCSrcE with rawStall gives FlushE=1 and FlushD=1, with StallF/StallD high.
- StallCount updates on the clk edge after the stalled cycle.

## Test plan
- FWD_EN=1, RdM=RdW=5, both RegWrite=1, Rs1E=5 -> ForwardAE=10. Rs1E=0 with RdM=0 -> ForwardAE=00.
- Load in E with RdE=7, RegWriteE=1, Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle. With RdE=0 -> no stall.
- LONG_LAT=4, LongStartE held -> StallE=1 for 3 cycles, FlushM=1 for 3 cycles, LongBusy=1 from cycle 2. LONG_LAT=1 -> no stall.
- Long op reaches cnt==0 while MemReqM=1 and MemReadyM=0 for 2 cycles -> FSM goes to DONE, StallE=1 only via memStall, FlushM=0, FlushW=1. FSM returns to RUN with no retrigger.
- PCSrcE=1 during memStall -> FlushD=FlushE=0 until MemReadyM=1, then FlushD=FlushE=1.
- CNT_W=3 with StallF held 10 cycles -> StallCount saturates at 7. Reset mid-count -> 0.
